// File: rtl/kogge_stone_pkg.sv
// Shared sizing helpers for the pipelined Kogge-Stone adder.
// Both the RTL and any instantiating block derive depth from these functions.
package kogge_stone_pkg;

  function automatic int ks_levels(input int width);
    return $clog2(width);
  endfunction

  // Number of register groups that follow the prefix levels.
  function automatic int ks_groups(input int width, input int reg_every);
    return (ks_levels(width) + reg_every - 1) / reg_every;
  endfunction

  function automatic int ks_lat(input int width, input int reg_every);
    return 1 + ks_groups(width, reg_every);
  endfunction

  // Prefix level whose output feeds pipeline register stage j (j >= 2).
  function automatic int ks_stage_src_level(input int j, input int reg_every);
    return (j - 1) * reg_every - 1;
  endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone (G,P) combine: merges a higher span with the adjacent lower span.
module ks_prefix_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);
  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;
endmodule

// File: rtl/kogge_stone_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with carry-in, carry-out, signed overflow
// and a collapsing valid/ready pipeline holding up to LAT beats.
module kogge_stone_pipe
  import kogge_stone_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS = ks_levels(WIDTH);
  localparam int LAT    = ks_lat(WIDTH, REG_EVERY);
  localparam int NMID   = LAT - 1;

  // Sideband that rides along with the prefix tree: half-sum and carry-in.
  typedef struct packed {
    logic [WIDTH-1:0] h;
    logic             cin;
  } side_t;

  logic [LAT:1]     v_q, v_d, adv;
  logic [LAT-1:0]   ld_v;
  logic             accept;

  logic [WIDTH-1:0] bx, h0, g0, p0;
  logic [WIDTH-1:0] g_in [1:NMID];
  logic [WIDTH-1:0] p_in [1:NMID];
  side_t            side_in [1:NMID];
  logic [WIDTH-1:0] g_q [1:NMID];
  logic [WIDTH-1:0] p_q [1:NMID];
  side_t            side_q [1:NMID];

  logic [LEVELS-1:0][WIDTH-1:0] lin_g, lin_p, lout_g, lout_p;
  logic             unused_p;

  logic [WIDTH-1:0] gf, s_d, s_q;
  logic             cout_d, cout_q, ovf_d, ovf_q;

  // Handshake: a stage moves when the next one is empty or moving itself.
  always_comb begin
    adv      = '0;
    adv[LAT] = v_q[LAT] & out_ready;
    for (int j = LAT - 1; j >= 1; j--) begin
      adv[j] = v_q[j] & (~v_q[j+1] | adv[j+1]);
    end
  end

  assign in_ready = ~v_q[1] | adv[1];
  assign accept   = in_valid & in_ready;
  assign ld_v     = {adv[LAT-1:1], accept};

  always_comb begin
    v_d = v_q;
    for (int j = 1; j <= LAT; j++) begin
      v_d[j] = (v_q[j] & ~adv[j]) | ld_v[j-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) v_q <= '0;
    else        v_q <= v_d;
  end

  // Stage 0: operand conditioning, carry-in folded into bit 0 generate.
  always_comb begin
    bx    = sub ? ~b : b;
    h0    = a ^ bx;
    g0    = a & bx;
    p0    = a | bx;
    g0[0] = g0[0] | (p0[0] & cin);
  end

  assign g_in[1]    = g0;
  assign p_in[1]    = p0;
  assign side_in[1] = {h0, cin};

  for (genvar j = 2; j <= NMID; j++) begin : g_mid_src
    assign g_in[j]    = lout_g[ks_stage_src_level(j, REG_EVERY)];
    assign p_in[j]    = lout_p[ks_stage_src_level(j, REG_EVERY)];
    assign side_in[j] = side_q[j-1];
  end

  // Stages 1..LAT-1: prefix state registers between level groups.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 1; j <= NMID; j++) begin
        g_q[j]    <= '0;
        p_q[j]    <= '0;
        side_q[j] <= '0;
      end
    end else begin
      for (int j = 1; j <= NMID; j++) begin
        if (ld_v[j-1]) begin
          g_q[j]    <= g_in[j];
          p_q[j]    <= p_in[j];
          side_q[j] <= side_in[j];
        end
      end
    end
  end

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int D = 1 << k;
    if (k % REG_EVERY == 0) begin : g_from_reg
      assign lin_g[k] = g_q[k / REG_EVERY + 1];
      assign lin_p[k] = p_q[k / REG_EVERY + 1];
    end else begin : g_from_comb
      assign lin_g[k] = lout_g[k-1];
      assign lin_p[k] = lout_p[k-1];
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i < D) begin : g_pass
        assign lout_g[k][i] = lin_g[k][i];
        assign lout_p[k][i] = lin_p[k][i];
      end else begin : g_cell
        ks_prefix_cell u_cell (
          .g_hi_i (lin_g[k][i]),
          .p_hi_i (lin_p[k][i]),
          .g_lo_i (lin_g[k][i-D]),
          .p_lo_i (lin_p[k][i-D]),
          .g_o    (lout_g[k][i]),
          .p_o    (lout_p[k][i])
        );
      end
    end
  end

  // The final propagate vector has no consumer.
  assign unused_p = ^lout_p[LEVELS-1];

  // Stage LAT: post-process into the output register.
  always_comb begin
    gf     = lout_g[LEVELS-1];
    s_d    = side_q[NMID].h ^ {gf[WIDTH-2:0], side_q[NMID].cin};
    cout_d = gf[WIDTH-1];
    ovf_d  = gf[WIDTH-2] ^ gf[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (ld_v[LAT-1]) begin
      s_q    <= s_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = v_q[LAT];
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
